pipe_addsub: RTL and testbench

- Parametrised, pipelined successor of the 32-bit combinational CLA adder, for the datapath ALU and address-generation paths.
- Splits a WIDTH-bit add/subtract into STAGES registered chunks, with the carry registered between chunks.
- Provides valid/ready handshaking and carry/overflow/zero flags, so wide adds close timing without stalling the whole core.

---
 rtl/pipe_addsub.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_addsub.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit adder/subtractor.
// The add is split into STAGES chunks of CW = WIDTH/STAGES bits. Each stage adds
// one chunk and registers the chunk carry for the next stage. The operand chunks
// that are not added yet, and the result chunks that are already done, move down
// skew registers alongside it. Flow control uses valid/ready. The stall is global:
// when the output is blocked, every stage holds and bubbles are kept.
// Optional feature: define PIPE_ADDSUB_SAT_EN to add a 'sat' input. When sat=1
// and the result overflows, the result saturates to the signed limit.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
`ifdef PIPE_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    // Writes one finished chunk into a partially built result word.
    function automatic logic [WIDTH-1:0] put_chunk(input logic [WIDTH-1:0] r,
                                                   input logic [CW-1:0]    c,
                                                   input int               idx);
        logic [WIDTH-1:0] v;
        v = r;
        v[idx*CW +: CW] = c;
        return v;
    endfunction

`ifdef PIPE_ADDSUB_SAT_EN
    // Returns the signed limit in the direction of the operand A sign.
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        logic [WIDTH-1:0] v;
        if (neg) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    // Handshake.
    logic advance_s;

    // Operand forming at the point of accept.
    logic [WIDTH-1:0] b_fmt_s;
    logic             c0_s;
    logic             sat_in0_s;

    // Inputs seen by each stage: stage 0 gets the accept side, later stages the previous register.
    logic [WIDTH-1:0] a_in_s   [STAGES];
    logic [WIDTH-1:0] b_in_s   [STAGES];
    logic [WIDTH-1:0] r_in_s   [STAGES];
    logic [STAGES-1:0] c_in_s;
    logic [STAGES-1:0] v_in_s;
    logic [STAGES-1:0] s_in_s;
    logic [CW:0]      chunk_s  [STAGES];
    logic [WIDTH-1:0] res_d    [STAGES];

    // Stage registers.
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  bp_q  [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] sat_q;

    // Output registers, loaded together with the final stage.
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Some skew bits are never read, for example the low chunks of A/B' that are already added.
    logic unused_s;

    assign advance_s = ~vld_q[STAGES-1] | out_ready;
    assign in_ready  = advance_s;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Forms B' and the initial carry from the opcode: bit 0 selects invert, bit 1 selects cin.
    always_comb begin
        b_fmt_s   = op[0] ? ~b : b;
        c0_s      = op[1] ? cin : op[0];
`ifdef PIPE_ADDSUB_SAT_EN
        sat_in0_s = sat;
`else
        sat_in0_s = 1'b0;
`endif
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign a_in_s[g] = a;
            assign b_in_s[g] = b_fmt_s;
            assign r_in_s[g] = '0;
            assign c_in_s[g] = c0_s;
            assign v_in_s[g] = in_valid;
            assign s_in_s[g] = sat_in0_s;
        end else begin : g_rest
            assign a_in_s[g] = a_q[g-1];
            assign b_in_s[g] = bp_q[g-1];
            assign r_in_s[g] = res_q[g-1];
            assign c_in_s[g] = cy_q[g-1];
            assign v_in_s[g] = vld_q[g-1];
            assign s_in_s[g] = sat_q[g-1];
        end
        assign chunk_s[g] = {1'b0, a_in_s[g][g*CW +: CW]}
                          + {1'b0, b_in_s[g][g*CW +: CW]}
                          + {{CW{1'b0}}, c_in_s[g]};
        assign res_d[g]   = put_chunk(r_in_s[g], chunk_s[g][CW-1:0], g);
    end

    // Final-stage result and flags; the sign bits come from the A/B' copies carried down the pipe.
    always_comb begin
        logic sa_v;
        logic sb_v;
        logic [WIDTH-1:0] raw_v;
        raw_v  = res_d[STAGES-1];
        sa_v   = a_in_s[STAGES-1][MSB];
        sb_v   = b_in_s[STAGES-1][MSB];
        cout_d = chunk_s[STAGES-1][CW];
        ovf_d  = (sa_v == sb_v) & (raw_v[MSB] != sa_v);
`ifdef PIPE_ADDSUB_SAT_EN
        if (s_in_s[STAGES-1] & ovf_d) begin
            sum_d = sat_value(sa_v);
        end else begin
            sum_d = raw_v;
        end
`else
        sum_d = raw_v;
`endif
        zero_d = ~|sum_d;
    end

    // Stage registers: shift on advance; the datapath loads only behind a valid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            sat_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                res_q[k] <= '0;
            end
        end else if (advance_s) begin
            vld_q <= v_in_s;
            for (int k = 0; k < STAGES; k++) begin
                if (v_in_s[k]) begin
                    a_q[k]   <= a_in_s[k];
                    bp_q[k]  <= b_in_s[k];
                    res_q[k] <= res_d[k];
                    cy_q[k]  <= chunk_s[k][CW];
                    sat_q[k] <= s_in_s[k];
                end
            end
        end
    end

    // Output registers: capture sum and flags when a valid beat leaves the final stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance_s && v_in_s[STAGES-1]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    // Collapses the skew bits that are never read, so this intent stays explicit.
    always_comb begin
        unused_s = ^{cy_q, sat_q};
        for (int k = 0; k < STAGES; k++) begin
            unused_s = unused_s ^ (^{a_q[k], bp_q[k], res_q[k]});
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Testbench for pipe_addsub. It builds three instances, with STAGES=1, 2 and 4.
// The instances run the same directed vectors. The expected values were
// computed by hand. Handshake corner cases run on the STAGES=2 instance.
module tb_pipe_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [1:0]  op;
`ifdef PIPE_ADDSUB_SAT_EN
    logic        sat;
`endif
    logic        out_ready2;

    logic        in_ready1, out_valid1, cout1, ovf1, zero1;
    logic        in_ready2, out_valid2, cout2, ovf2, zero2;
    logic        in_ready4, out_valid4, cout4, ovf4, zero4;
    logic [31:0] sum1, sum2, sum4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sat;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[16];
    int   n_vec = 0;

    pipe_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .op(op),
`ifdef PIPE_ADDSUB_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1),
        .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    pipe_addsub #(.WIDTH(32), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .cin(cin), .op(op),
`ifdef PIPE_ADDSUB_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
        .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    pipe_addsub #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .op(op),
`ifdef PIPE_ADDSUB_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid4), .out_ready(1'b1), .sum(sum4),
        .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic v, input logic c, input logic o,
                                       input logic z, input logic [31:0] s);
        return {28'd0, v, c, o, z, s};
    endfunction

    task automatic add_vec(input logic [1:0] vop, input logic [31:0] va, input logic [31:0] vb,
                           input logic vcin, input logic vsat, input logic [31:0] vsum,
                           input logic vcout, input logic vovf, input logic vzero);
        vecs[n_vec].op   = vop;
        vecs[n_vec].a    = va;
        vecs[n_vec].b    = vb;
        vecs[n_vec].cin  = vcin;
        vecs[n_vec].sat  = vsat;
        vecs[n_vec].sum  = vsum;
        vecs[n_vec].cout = vcout;
        vecs[n_vec].ovf  = vovf;
        vecs[n_vec].zero = vzero;
        n_vec++;
    endtask

    task automatic drive(input logic [1:0] vop, input logic [31:0] va, input logic [31:0] vb,
                         input logic vcin);
        op  = vop;
        a   = va;
        b   = vb;
        cin = vcin;
    endtask

    initial begin
        logic [63:0] exp_v;

        // Fields: op, a, b, cin, sat, then the expected sum, cout, ovf, zero.
        add_vec(2'b00, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        add_vec(2'b01, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        add_vec(2'b01, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        add_vec(2'b10, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        add_vec(2'b10, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
        add_vec(2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        add_vec(2'b11, 32'h00000010, 32'h00000003, 1'b0, 1'b0, 32'h0000000C, 1'b1, 1'b0, 1'b0);
        add_vec(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        add_vec(2'b01, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        add_vec(2'b00, 32'h12345678, 32'h0000ABCD, 1'b0, 1'b0, 32'h12350245, 1'b0, 1'b0, 1'b0);
        add_vec(2'b11, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_ADDSUB_SAT_EN
        add_vec(2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        add_vec(2'b00, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
        add_vec(2'b00, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0);
        sat = 1'b0;
`endif

        // Reset state, with out_ready low so that in_ready has to come from out_valid=0.
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready2 = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        #2;
        check("reset_out2", pk(out_valid2, cout2, ovf2, zero2, sum2), 64'd0);
        check("reset_in_ready2", 64'(in_ready2), 64'd1);
        check("reset_out4", pk(out_valid4, cout4, ovf4, zero4, sum4), 64'd0);
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        out_ready2 = 1'b1;
        @(negedge clk);
        check("post_reset_valid2", 64'(out_valid2), 64'd0);
        check("post_reset_valid1", 64'(out_valid1), 64'd0);

        // Table: one beat per vector, checked at the exact latency of each instance.
        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
`ifdef PIPE_ADDSUB_SAT_EN
            sat = vecs[i].sat;
`endif
            in_valid = 1'b1;
            check($sformatf("v%0d_in_ready", i), {62'd0, in_ready1, in_ready4}, 64'd3);
            exp_v = pk(1'b1, vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].sum);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d_stages1", i), pk(out_valid1, cout1, ovf1, zero1, sum1), exp_v);
            check($sformatf("v%0d_stages2_early", i), 64'(out_valid2), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_stages2", i), pk(out_valid2, cout2, ovf2, zero2, sum2), exp_v);
            @(negedge clk);
            check($sformatf("v%0d_stages4_early", i), 64'(out_valid4), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_stages4", i), pk(out_valid4, cout4, ovf4, zero4, sum4), exp_v);
        end
`ifdef PIPE_ADDSUB_SAT_EN
        sat = 1'b0;
`endif

        // Back-to-back ADDC beats, one result per cycle.
        @(negedge clk);
        drive(2'b10, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", 64'(in_ready2), 64'd1);
        drive(2'b10, 32'h00000001, 32'h00000001, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_first", pk(out_valid2, cout2, ovf2, zero2, sum2),
              pk(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000));
        @(negedge clk);
        check("b2b_second", pk(out_valid2, cout2, ovf2, zero2, sum2),
              pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000002));
        @(negedge clk);
        check("b2b_drained", 64'(out_valid2), 64'd0);

        // Stall: the output is blocked with the pipe full and a third beat waiting.
        out_ready2 = 1'b0;
        drive(2'b00, 32'h00000001, 32'h00000002, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        drive(2'b00, 32'h00000010, 32'h00000020, 1'b0);
        @(negedge clk);
        drive(2'b01, 32'h00000100, 32'h00000001, 1'b0);
        check("stall_in_ready", 64'(in_ready2), 64'd0);
        check("stall_head", pk(out_valid2, cout2, ovf2, zero2, sum2),
              pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000003));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d_in_ready", c), 64'(in_ready2), 64'd0);
            check($sformatf("stall_hold%0d_out", c), pk(out_valid2, cout2, ovf2, zero2, sum2),
                  pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000003));
        end
        out_ready2 = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready2), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("release_second", pk(out_valid2, cout2, ovf2, zero2, sum2),
              pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000030));
        @(negedge clk);
        check("release_third", pk(out_valid2, cout2, ovf2, zero2, sum2),
              pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h000000FF));
        @(negedge clk);
        check("release_drained", 64'(out_valid2), 64'd0);

        // Reset while two beats are in flight.
        drive(2'b00, 32'h00000005, 32'h00000006, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        drive(2'b00, 32'h00000007, 32'h00000008, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_before", pk(out_valid2, cout2, ovf2, zero2, sum2),
              pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000000B));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_async_drop", 64'(out_valid2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("midrst_no_stale%0d", c), {62'd0, out_valid2, out_valid4}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
